// File: rtl/btn_debounce_pulse.sv
// Push-button conditioning for the ALU front panel.
// Each raw button is synchronised with two flip-flops, filtered so that a new
// level is only accepted after it has been stable for DB_CYCLES clocks, and
// converted into a debounced level plus a one-cycle pulse on every accepted
// press. Buttons are handled completely independently of one another.
module btn_debounce_pulse #(
  parameter int NB_BTN    = 3,
  parameter int DB_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_db,
  output logic [NB_BTN-1:0] o_btn_pulse
);

  localparam int NB_CNT = $clog2(DB_CYCLES);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DB_CYCLES - 1);

  typedef enum logic {
    IDLE_LOW  = 1'b0,
    HELD_HIGH = 1'b1
  } state_t;

  logic [NB_BTN-1:0] r_sync1;
  logic [NB_BTN-1:0] r_sync2;
  logic [NB_BTN-1:0] r_pulse;
  state_t            r_state     [NB_BTN];
  logic [NB_CNT-1:0] r_cnt       [NB_BTN];
  state_t            w_stateNext [NB_BTN];
  logic [NB_CNT-1:0] w_cntNext   [NB_BTN];
  logic [NB_BTN-1:0] w_pulseNext;

  // Two-flop synchroniser bringing the asynchronous buttons into the clock domain
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Filter state register: accepted stable level and stability counter per button
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB_BTN; i++) begin
      if (!i_reset) begin
        r_state[i] <= IDLE_LOW;
        r_cnt[i]   <= '0;
      end else begin
        r_state[i] <= w_stateNext[i];
        r_cnt[i]   <= w_cntNext[i];
      end
    end
  end

  // Next-state logic: count while the synchronised input disagrees, flip after the last count
  always_comb begin
    for (int i = 0; i < NB_BTN; i++) begin
      w_stateNext[i] = r_state[i];
      w_cntNext[i]   = '0;
      if (r_sync2[i] != (r_state[i] == HELD_HIGH)) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stateNext[i] = (r_state[i] == IDLE_LOW) ? HELD_HIGH : IDLE_LOW;
          w_cntNext[i]   = '0;
        end else begin
          w_cntNext[i]   = r_cnt[i] + NB_CNT'(1);
        end
      end
    end
  end

  // Output decode: level follows the stable state, a pulse is armed only on a low-to-high flip
  always_comb begin
    for (int i = 0; i < NB_BTN; i++) begin
      o_btn_db[i]    = (r_state[i] == HELD_HIGH);
      w_pulseNext[i] = (r_state[i] == IDLE_LOW) && (w_stateNext[i] == HELD_HIGH);
    end
  end

  // Pulse register so the load enables downstream come straight from a flop
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_pulseNext;
    end
  end

  assign o_btn_pulse = r_pulse;

endmodule
